// File: rtl/io_irq_port_pkg.sv
// rtl/io_irq_port_pkg.sv - shared register map and bit indices for io_irq_port
//
// Purpose : register offsets within the 4-byte window, STATUS and CTRL bit
//           positions, shared by the top level and the timer.
// Ports   : none (package).
package io_irq_port_pkg;

  typedef enum logic [1:0] {
    REG_PORT   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_TIMER  = 2'd3
  } reg_off_e;

  // STATUS bit indices
  localparam int TIF = 0;
  localparam int EIF = 1;
  localparam int NIF = 2;

  // CTRL bit indices
  localparam int TEN = 0;
  localparam int TIE = 1;
  localparam int EIE = 2;

endpackage

// File: rtl/io_irq_timer.sv
// rtl/io_irq_timer.sv - prescaled programmable interval timer
//
// Purpose : prescaler 0..PRESCALE-1 whose wrap is a tick; each tick either
//           decrements COUNT or, at zero, reloads it and pulses expire.
// Ports   : clk, reset_n     clock, async active-low reset
//           en               advance enable (TEN & ce)
//           load             load RELOAD/COUNT from load_value, zero prescaler
//           load_value[7:0]  value for load
//           count[7:0]       current COUNT
//           expire           one-cycle pulse when a tick finds COUNT==0
module io_irq_timer #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] count,
  output logic       expire
);

  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [7:0] prescale_q, prescale_d;
  logic [7:0] count_q, count_d;
  logic [7:0] reload_q, reload_d;
  logic       tick;

  assign tick   = en && (prescale_q == PS_LAST);
  // A load in the same cycle as a tick wins, so the tick must not expire.
  assign expire = tick && (count_q == 8'd0) && !load;
  assign count  = count_q;

  always_comb begin
    prescale_d = prescale_q;
    count_d    = count_q;
    reload_d   = reload_q;
    if (load) begin
      reload_d   = load_value;
      count_d    = load_value;
      prescale_d = 8'd0;
    end else if (en) begin
      prescale_d = tick ? 8'd0 : prescale_q + 8'd1;
      if (tick) begin
        count_d = (count_q == 8'd0) ? reload_q : count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= 8'd0;
      count_q    <= 8'd0;
      reload_q   <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
    end
  end

endmodule

// File: rtl/io_irq_port.sv
// rtl/io_irq_port.sv - memory-mapped output port, interrupt status/control and timer
//
// Purpose : 4-byte register window at BASE_ADDR on the cpu6502 bus: PORT,
//           STATUS (W1C), CTRL, TIMER. Drives irq/nmi from latched sources.
//           Build option IO_IRQ_PORT_SYNC_EN adds 2-flop synchronizers on
//           ext_irq_i/ext_nmi_i ahead of edge detection.
// Ports   : clk, reset_n       clock, async active-low reset
//           ce                 CPU clock enable (bus writes, timer advance)
//           address[15:0]      CPU address
//           write, data_i[7:0] CPU write strobe and data
//           data_o[7:0]        read data (00 when not selected)
//           cs                 address falls inside the window
//           port_o[7:0]        PORT register
//           ext_irq_i/ext_nmi_i  rising-edge interrupt requests
//           irq, nmi           interrupt outputs to the CPU
module io_irq_port
  import io_irq_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hbffc,
  parameter int          PRESCALE   = 16,
  parameter logic [7:0]  PORT_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        cs,
  output logic [7:0]  port_o,
  input  logic        ext_irq_i,
  input  logic        ext_nmi_i,
  output logic        irq,
  output logic        nmi
);

  logic [7:0] port_q, port_d;
  logic [2:0] status_q, status_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic       irq_prev_q, nmi_prev_q;
  logic       irq_in, nmi_in;
  logic       wr_en;
  reg_off_e   offset;
  logic [7:0] count;
  logic       expire;
  logic       timer_load;
  logic [2:0] status_set, status_clr;

  assign cs     = (address[15:2] == BASE_ADDR[15:2]);
  assign offset = reg_off_e'(address[1:0]);
  assign wr_en  = cs && write && ce;

`ifdef IO_IRQ_PORT_SYNC_EN
  logic irq_s1_q, irq_s2_q, nmi_s1_q, nmi_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
      nmi_s1_q <= 1'b0;
      nmi_s2_q <= 1'b0;
    end else begin
      irq_s1_q <= ext_irq_i;
      irq_s2_q <= irq_s1_q;
      nmi_s1_q <= ext_nmi_i;
      nmi_s2_q <= nmi_s1_q;
    end
  end

  assign irq_in = irq_s2_q;
  assign nmi_in = nmi_s2_q;
`else
  assign irq_in = ext_irq_i;
  assign nmi_in = ext_nmi_i;
`endif

  assign timer_load = wr_en && (offset == REG_TIMER);

  io_irq_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (ctrl_q[TEN] && ce),
    .load       (timer_load),
    .load_value (data_i),
    .count      (count),
    .expire     (expire)
  );

  always_comb begin
    status_set      = 3'b000;
    status_set[TIF] = expire;
    status_set[EIF] = irq_in && !irq_prev_q;
    status_set[NIF] = nmi_in && !nmi_prev_q;
  end

  assign status_clr = (wr_en && (offset == REG_STATUS)) ? data_i[2:0] : 3'b000;

  always_comb begin
    port_d   = port_q;
    ctrl_d   = ctrl_q;
    // Set is applied after the clear so a coincident source event wins.
    status_d = (status_q & ~status_clr) | status_set;
    if (wr_en) begin
      case (offset)
        REG_PORT: port_d = data_i;
        REG_CTRL: ctrl_d = data_i[2:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q     <= PORT_RESET;
      status_q   <= 3'b000;
      ctrl_q     <= 3'b000;
      irq_prev_q <= 1'b0;
      nmi_prev_q <= 1'b0;
    end else begin
      port_q     <= port_d;
      status_q   <= status_d;
      ctrl_q     <= ctrl_d;
      irq_prev_q <= irq_in;
      nmi_prev_q <= nmi_in;
    end
  end

  always_comb begin
    data_o = 8'h00;
    if (cs) begin
      case (offset)
        REG_PORT:   data_o = port_q;
        REG_STATUS: data_o = {5'b00000, status_q};
        REG_CTRL:   data_o = {5'b00000, ctrl_q};
        REG_TIMER:  data_o = count;
        default:    data_o = 8'h00;
      endcase
    end
  end

  assign port_o = port_q;
  assign irq    = (status_q[TIF] && ctrl_q[TIE]) || (status_q[EIF] && ctrl_q[EIE]);
  assign nmi    = status_q[NIF];

endmodule

// File: doc/io_irq_port.md
Name: io_irq_port

Overview:
- Memory-mapped I/O responder on the cpu6502 bus: the device side of the CPU's `address`/`write`/`data_o`/`data_i` interface.
- Provides four registers in a 4-byte window at BASE_ADDR:
  - an 8-bit output port;
  - an interrupt status register, cleared by writing 1s;
  - a control register;
  - a programmable interval timer.
- Drives the CPU `irq`/`nmi` inputs from latched interrupt sources.
- Sits between the CPU core and the system read-data mux; `cs` tells the mux to select `data_o`.

Parameters:
- BASE_ADDR, 16'hbffc: window base; must be 4-byte aligned (address[1:0]==0).
- PRESCALE, 16: clk cycles per timer tick; legal range 1..256.
- PORT_RESET, 8'h00: reset value of the PORT register.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  CPU clock enable; qualifies bus writes and timer advance.
- address  in  16  CPU address bus.
- write  in  1  CPU write strobe, active high.
- data_i  in  8  write data from the CPU.
- data_o  out  8  read data to the CPU.
- cs  out  1  high when address is in [BASE_ADDR, BASE_ADDR+3].
- port_o  out  8  PORT register contents.
- ext_irq_i  in  1  external maskable interrupt request; rising-edge sensitive.
- ext_nmi_i  in  1  external non-maskable request; rising-edge sensitive.
- irq  out  1  active-high interrupt to the CPU.
- nmi  out  1  active-high NMI to the CPU.

Behaviour:
- Reset (async, reset_n=0) forces:
  - PORT=PORT_RESET, STATUS=0, CTRL=0, RELOAD=0, COUNT=0, prescaler=0;
  - edge-detect flops=0;
  - irq=0, nmi=0, port_o=PORT_RESET.
  - Asserting reset mid-count or mid-write aborts immediately; nothing is retained.
- Decode: `cs` = (address[15:2]==BASE_ADDR[15:2]), purely combinational.
- Register map (offset = address[1:0]):
  - 0 PORT: R/W.
  - 1 STATUS: {5'b0,NIF,EIF,TIF}; W1C (write 1 to clear).
  - 2 CTRL: {5'b0,EIE,TIE,TEN}; R/W, bits 7:3 read 0.
  - 3 TIMER: write loads RELOAD and COUNT and zeroes the prescaler; read returns COUNT.
- Write:
  - Takes effect on the posedge where cs & write & ce are all 1.
  - Written register is visible on data_o in the next cycle.
- Read:
  - data_o is a combinational mux of address[1:0]; it is 8'h00 when cs=0.
  - Reads have no side effects.
- Timer:
  - Advances only when TEN=1 and ce=1.
  - Prescaler counts 0..PRESCALE-1; its wrap is a tick.
  - On a tick: if COUNT==0, set TIF and reload COUNT<=RELOAD; otherwise COUNT<=COUNT-1.
  - Period = (RELOAD+1)*PRESCALE enabled cycles. RELOAD=0 gives a TIF every tick.
  - Clearing TEN freezes COUNT and the prescaler; they are not cleared.
- Edges:
  - A rising edge of ext_irq_i sets EIF; a rising edge of ext_nmi_i sets NIF.
  - Latency is 1 cycle after the input is sampled high.
  - Edge detection runs regardless of ce.
- Outputs:
  - irq = (TIF&TIE)|(EIF&EIE), registered-status combinational; masked sources remain latched.
  - nmi = NIF.
- Simultaneous set and W1C clear of the same STATUS bit: set wins, and the bit stays 1.
- Simultaneous TIMER write and tick: the write wins, and no TIF is set that cycle.

Optional Feature:
- Macro IO_IRQ_PORT_SYNC_EN.
- Defined: ext_irq_i and ext_nmi_i each pass through a 2-flop synchronizer, reset to 0, before edge detection. Set latency becomes 3 cycles.
- Undefined: inputs are edge-detected directly, with 1-cycle latency. In this case the inputs are required to be synchronous to clk.

Decomposition:
- Shared package io_irq_port_pkg holds:
  - register offsets REG_PORT=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_TIMER=2'd3;
  - STATUS bit indices TIF=0, EIF=1, NIF=2;
  - CTRL bit indices TEN=0, TIE=1, EIE=2.
- One sub-module, io_irq_timer, is natural:
  - contains the prescaler and COUNT/RELOAD;
  - inputs: en, load, load_value;
  - outputs: count, expire pulse.

Test Plan:
- Reset, then read offsets 0..3 with BASE_ADDR=16'hbffc -> data_o=00,00,00,00; cs=1 only for 16'hbffc..bfff; irq=0, nmi=0.
- Write 8'hA5 to 16'hbffc with ce=1 -> port_o=A5 next cycle. Repeat with ce=0 -> port_o unchanged.
- PRESCALE=4: write TIMER=3, CTRL=8'h03 -> TIF and irq rise exactly 16 enabled cycles after TEN is set. Write STATUS=8'h01 -> irq drops next cycle; the next TIF follows 16 cycles after the reload.
- Pulse ext_irq_i high with EIE=0 -> STATUS=8'h02, irq=0. Then write CTRL=8'h04 -> irq=1 with no new edge required.
- Pulse ext_nmi_i -> nmi=1 after 1 cycle (3 with IO_IRQ_PORT_SYNC_EN). Holding it high causes no re-set after a W1C of 8'h04.
- Same-cycle W1C of TIF and timer expiry -> TIF stays 1. Assert reset_n=0 mid-count -> all outputs go to reset values without waiting for clk.
